// File: rtl/seq_pkg.sv
// Shared definitions for the A-line sequence generator and detector.
// One-hot state encodings and the default phase-counter width.
package seq_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_HIGH1 = 4'b0010;
    localparam logic [3:0] ST_LOW   = 4'b0100;
    localparam logic [3:0] ST_HIGH2 = 4'b1000;

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter timing each phase of the A waveform.
// Priority: clear, then load, then decrement.
module phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] ld_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_stim_gen.sv
// Generates the high/low/high A-line pattern that drives a sequence
// detector, with programmable phase lengths and start/busy/done handshake.
module seq_stim_gen
    import seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len_hi1,
    input  logic [CNT_W-1:0] len_lo,
    input  logic [CNT_W-1:0] len_hi2,
    output logic             a_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    logic [3:0]       state;
    logic [3:0]       nxt_state;
    logic             nxt_a;
    logic             nxt_busy;
    logic             nxt_done;
    logic             cnt_clr;
    logic             cnt_ld;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             take;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] lo_len;
    logic [CNT_W-1:0] hi2_len;

    phase_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .load   (cnt_ld),
        .dec    (cnt_dec),
        .ld_val (ld_val),
        .zero   (cnt_zero)
    );

    always_comb begin
        nxt_state = state;
        nxt_a     = a_out;
        nxt_busy  = busy;
        nxt_done  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_ld    = 1'b0;
        cnt_dec   = 1'b0;
        take      = 1'b0;
        ld_val    = '0;
        case (state)
            ST_IDLE: begin
                nxt_a    = 1'b0;
                nxt_busy = 1'b0;
                if (start && !abort) begin
                    nxt_state = ST_HIGH1;
                    nxt_a     = 1'b1;
                    nxt_busy  = 1'b1;
                    cnt_ld    = 1'b1;
                    ld_val    = clamp1(len_hi1) - 1'b1;
                    take      = 1'b1;
                end
            end
            ST_HIGH1, ST_LOW, ST_HIGH2: begin
                if (abort) begin
                    nxt_state = ST_IDLE;
                    nxt_a     = 1'b0;
                    nxt_busy  = 1'b0;
                    cnt_clr   = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    unique case (1'b1)
                        state[1]: begin
                            nxt_state = ST_LOW;
                            nxt_a     = 1'b0;
                            cnt_ld    = 1'b1;
                            ld_val    = lo_len - 1'b1;
                        end
                        state[2]: begin
                            nxt_state = ST_HIGH2;
                            nxt_a     = 1'b1;
                            cnt_ld    = 1'b1;
                            ld_val    = hi2_len - 1'b1;
                        end
                        default: begin
                            nxt_state = ST_IDLE;
                            nxt_a     = 1'b0;
                            nxt_busy  = 1'b0;
                            nxt_done  = 1'b1;
                            cnt_clr   = 1'b1;
                        end
                    endcase
                end
            end
            // Corrupted (non-one-hot) state recovers to a quiet IDLE.
            default: begin
                nxt_state = ST_IDLE;
                nxt_a     = 1'b0;
                nxt_busy  = 1'b0;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            a_out <= nxt_a;
            busy  <= nxt_busy;
            done  <= nxt_done;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            lo_len  <= '0;
            hi2_len <= '0;
        end else if (take) begin
            lo_len  <= clamp1(len_lo);
            hi2_len <= clamp1(len_hi2);
        end
    end

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench: stimulus queues hand-written per-cycle expectations,
// monitors pop and compare after each edge and on async reset.
module tb_seq_stim_gen;

    typedef struct {
        string tag;
        int    idx;
        logic  a;
        logic  b;
        logic  d;
    } exp_t;

    logic       sclk    = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] len_hi1 = '0;
    logic [7:0] len_lo  = '0;
    logic [7:0] len_hi2 = '0;
    logic       a_out;
    logic       busy;
    logic       done;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    event async_chk;

    seq_stim_gen #(
        .CNT_W (8)
    ) dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .len_hi1 (len_hi1),
        .len_lo  (len_lo),
        .len_hi2 (len_hi2),
        .a_out   (a_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input exp_t e);
        n_chk++;
        if (a_out === e.a && busy === e.b && done === e.d) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: a_out/busy/done got %b%b%b want %b%b%b",
                     e.tag, e.idx, a_out, busy, done, e.a, e.b, e.d);
        end
    endtask

    initial begin
        forever begin
            @(posedge sclk);
            #1;
            if (q.size() > 0) chk(q.pop_front());
        end
    end

    initial begin
        forever begin
            @(async_chk);
            #1;
            if (q.size() > 0) chk(q.pop_front());
        end
    end

    task automatic run(input string tag, input string st, input string ab,
                       input string ea, input string eb, input string ed);
        exp_t e;
        for (int i = 0; i < st.len(); i++) begin
            @(negedge sclk);
            start = (st[i] == "1");
            abort = (ab[i] == "1");
            e.tag = tag;
            e.idx = i;
            e.a   = (ea[i] == "1");
            e.b   = (eb[i] == "1");
            e.d   = (ed[i] == "1");
            q.push_back(e);
        end
    endtask

    task automatic set_len(input logic [7:0] h1, input logic [7:0] lo,
                           input logic [7:0] h2);
        len_hi1 = h1;
        len_lo  = lo;
        len_hi2 = h2;
    endtask

    initial begin
        exp_t e;
        run("rst", "000", "000", "000", "000", "000");
        @(negedge sclk);
        rst_n = 1'b1;
        run("idle", "0000000000", "0000000000", "0000000000",
            "0000000000", "0000000000");

        set_len(8'd3, 8'd2, 8'd4);
        run("basic", "10000000000", "00000000000", "11100111100",
            "11111111100", "00000000010");

        set_len(8'd0, 8'd0, 8'd0);
        run("zero", "10000", "00000", "10100", "11100", "00010");

        set_len(8'd5, 8'd5, 8'd5);
        run("abort", "100000000", "000000010", "111110000",
            "111111100", "000000000");
        run("post_abort", "10000000000000000", "00000000000000000",
            "11111000001111100", "11111111111111100",
            "00000000000000010");

        set_len(8'd1, 8'd1, 8'd1);
        run("held", "11111111111100", "00000000000000",
            "10101010101000", "11101110111000", "00010001000100");

        run("st_ab", "111", "111", "000", "000", "000");

        set_len(8'd2, 8'd1, 8'd3);
        run("latch_a", "10", "00", "11", "11", "00");
        set_len(8'd2, 8'd9, 8'd7);
        run("latch_b", "000000", "000000", "011100", "111100", "000010");

        set_len(8'd2, 8'd2, 8'd3);
        run("pre_rst", "100000", "000000", "110011", "111111", "000000");
        @(posedge sclk);
        #3;
        e.tag = "async";
        e.idx = 0;
        e.a   = 1'b0;
        e.b   = 1'b0;
        e.d   = 1'b0;
        q.push_back(e);
        rst_n = 1'b0;
        -> async_chk;
        run("rst2", "000", "000", "000", "000", "000");
        @(negedge sclk);
        rst_n = 1'b1;
        set_len(8'd1, 8'd2, 8'd1);
        run("post_rst", "100000", "000000", "100100", "111100", "000010");

        repeat (3) @(negedge sclk);
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far",
                 n_pass, n_chk);
        $fatal(1);
    end

endmodule
